// File: rtl/simplex8_pkg.sv
// Shared definitions for the Simplex8 unit-select path.
// Holds the code/line widths, the FSM state type of the request encoder,
// and the code-to-one-hot mapping used by the 3-to-8 select decoder.
package simplex8_pkg;

    localparam int CODE_W = 3;
    localparam int LINES  = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // Line bit (7-k) corresponds to code k: code 0 selects bit7.
    function automatic logic [LINES-1:0] code_to_onehot(input logic [CODE_W-1:0] k);
        logic [CODE_W-1:0] idx;
        idx = 3'd7 - k;
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Fixed-priority encoder for the 8 pending request bits.
// Ports:
//   pending  in   8  request bitmap, bit7 highest priority
//   sel      out  3  code of the highest set bit (code k = 7 - bit index)
//   any      out  1  at least one bit set
// The bit-to-code mapping is the exact inverse of code_to_onehot().
module prio_enc8
    import simplex8_pkg::*;
(
    input  logic [LINES-1:0]  pending,
    output logic [CODE_W-1:0] sel,
    output logic              any
);

    always_comb begin
        sel = '0;
        any = |pending;
        // Ascending scan: a higher set bit overwrites a lower one.
        for (int i = 0; i < LINES; i++) begin
            if (pending[i]) begin
                sel = CODE_W'(LINES - 1 - i);
            end
        end
    end

endmodule

// File: rtl/req_encoder8_3.sv
// Request encoder: captures 8 request lines into a pending bitmap and
// presents them one at a time as a 3-bit code with a valid/ack handshake.
// Ports:
//   clk      in   1  system clock
//   rst      in   1  synchronous active-high reset
//   en       in   1  capture enable
//   req      in   8  request lines, bit (7-k) maps to code k
//   clr      in   1  synchronous clear of pending/handshake state
//   ack      in   1  consumer accepts presented code
//   code     out  3  presented code, stable while valid
//   valid    out  1  code is valid
//   pending  out  8  registered pending bitmap
//   busy     out  1  pending != 0 or valid
//
// state   | meaning
// IDLE    | nothing presented; load highest pending code when any bit set
// PRESENT | code frozen and valid until ack
module req_encoder8_3
    import simplex8_pkg::*;
#(
    parameter int EDGE = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [LINES-1:0]  req,
    input  logic              clr,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [LINES-1:0]  pending,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [LINES-1:0]  pending_q, pending_d;
    logic [LINES-1:0]  req_q;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;

    logic [LINES-1:0]  hit;
    logic [LINES-1:0]  served;
    logic [CODE_W-1:0] sel;
    logic              any;

    prio_enc8 u_prio (
        .pending (pending_q),
        .sel     (sel),
        .any     (any)
    );

    always_comb begin
        hit = '0;
        if (en) begin
            hit = (EDGE != 0) ? (req & ~req_q) : req;
        end
    end

    assign served = (valid_q && ack) ? code_to_onehot(code_q) : '0;

    // OR-ing hit last lets a same-cycle re-request win over the clear.
    assign pending_d = (pending_q & ~served) | hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            req_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
        end else if (clr) begin
            state_q   <= IDLE;
            pending_q <= '0;
            // Keep tracking the lines so a held request does not re-fire.
            req_q     <= req;
            code_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req;
            code_q    <= code_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any) state_d = PRESENT;
            PRESENT: if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    code_d  = sel;
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                // Code stays frozen even if a higher-priority bit arrives.
                if (ack) valid_d = 1'b0;
            end
            default: valid_d = 1'b0;
        endcase
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign busy    = (|pending_q) | valid_q;

endmodule

// File: tb/tb_req_encoder8_3.sv
module tb_req_encoder8_3;
    import simplex8_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clr, ack;
    logic [7:0] req;
    logic [2:0] code;
    logic       valid, busy;
    logic [7:0] pending;

    logic       en2, clr2, ack2;
    logic [7:0] req2;
    logic [2:0] code2;
    logic       valid2, busy2;
    logic [7:0] pending2;

    logic [7:0] pe_in;
    logic [2:0] pe_sel;
    logic       pe_any;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    req_encoder8_3 #(.EDGE(1)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .clr(clr), .ack(ack),
        .code(code), .valid(valid), .pending(pending), .busy(busy)
    );

    req_encoder8_3 #(.EDGE(0)) dut_lvl (
        .clk(clk), .rst(rst), .en(en2), .req(req2), .clr(clr2), .ack(ack2),
        .code(code2), .valid(valid2), .pending(pending2), .busy(busy2)
    );

    prio_enc8 u_pe (.pending(pe_in), .sel(pe_sel), .any(pe_any));

    typedef struct {
        logic [7:0] in;
        logic [2:0] sel;
        logic       any;
        logic [7:0] onehot;
    } pe_vec_t;

    typedef struct {
        logic [7:0] req;
        logic [2:0] code;
    } pulse_vec_t;

    pe_vec_t    pe_tab[9];
    pulse_vec_t pulse_tab[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve every presentation until the encoder goes idle; bounded.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (busy && n < 60) begin
            ack = valid;
            tick();
            n++;
        end
        ack = 1'b0;
        chk({name, "_drained"}, {31'd0, busy}, 32'd0);
    endtask

    logic [2:0] exp_a5[4];

    initial begin
        pe_tab[0] = '{8'h00, 3'd0, 1'b0, 8'h00};
        pe_tab[1] = '{8'h80, 3'd0, 1'b1, 8'h80};
        pe_tab[2] = '{8'h01, 3'd7, 1'b1, 8'h01};
        pe_tab[3] = '{8'hA5, 3'd0, 1'b1, 8'h80};
        pe_tab[4] = '{8'h5A, 3'd1, 1'b1, 8'h40};
        pe_tab[5] = '{8'h0F, 3'd4, 1'b1, 8'h08};
        pe_tab[6] = '{8'h30, 3'd2, 1'b1, 8'h20};
        pe_tab[7] = '{8'h06, 3'd5, 1'b1, 8'h04};
        pe_tab[8] = '{8'h03, 3'd6, 1'b1, 8'h02};

        pulse_tab[0] = '{8'h01, 3'd7};
        pulse_tab[1] = '{8'h80, 3'd0};
        pulse_tab[2] = '{8'h0C, 3'd4};
        pulse_tab[3] = '{8'h03, 3'd6};
        pulse_tab[4] = '{8'h18, 3'd3};

        exp_a5[0] = 3'd0; exp_a5[1] = 3'd2; exp_a5[2] = 3'd5; exp_a5[3] = 3'd7;

        rst = 1'b1; en = 1'b1; clr = 1'b0; ack = 1'b0; req = 8'hFF;
        en2 = 1'b0; clr2 = 1'b0; ack2 = 1'b0; req2 = 8'h00;
        pe_in = 8'h00;

        // Priority encoder + decoder cross-check
        for (int i = 0; i < 9; i++) begin
            pe_in = pe_tab[i].in;
            #1;
            chk($sformatf("pe_sel_%0h", pe_tab[i].in), {29'd0, pe_sel}, {29'd0, pe_tab[i].sel});
            chk($sformatf("pe_any_%0h", pe_tab[i].in), {31'd0, pe_any}, {31'd0, pe_tab[i].any});
            if (pe_tab[i].any)
                chk($sformatf("pe_dec_%0h", pe_tab[i].in), {24'd0, code_to_onehot(pe_sel)},
                    {24'd0, pe_tab[i].onehot});
        end

        // Reset with all lines held high
        tick(); tick();
        chk("rst_pending", {24'd0, pending}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_code", {29'd0, code}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; req = 8'h00;
        tick(); tick();
        chk("post_rst_pending", {24'd0, pending}, 32'h0);
        chk("post_rst_valid", {31'd0, valid}, 32'd0);

        // Single pulse 01, ack on the cycle valid rises
        req = 8'h01;
        tick(); req = 8'h00;
        chk("p01_pending_n1", {24'd0, pending}, 32'h01);
        chk("p01_valid_n1", {31'd0, valid}, 32'd0);
        tick();
        chk("p01_valid_n2", {31'd0, valid}, 32'd1);
        chk("p01_code_n2", {29'd0, code}, 32'd7);
        ack = 1'b1;
        tick(); ack = 1'b0;
        chk("p01_valid_m1", {31'd0, valid}, 32'd0);
        tick();
        chk("p01_pending_m2", {24'd0, pending}, 32'h0);
        chk("p01_valid_m2", {31'd0, valid}, 32'd0);
        chk("p01_busy_m2", {31'd0, busy}, 32'd0);

        // Table of single pulses: first presented code
        for (int i = 0; i < 5; i++) begin
            req = pulse_tab[i].req;
            tick(); req = 8'h00;
            tick();
            chk($sformatf("pulse_valid_%0h", pulse_tab[i].req), {31'd0, valid}, 32'd1);
            chk($sformatf("pulse_code_%0h", pulse_tab[i].req), {29'd0, code}, {29'd0, pulse_tab[i].code});
            drain($sformatf("pulse_%0h", pulse_tab[i].req));
        end

        // A5: codes 0,2,5,7 with 2-cycle spacing
        req = 8'hA5;
        tick(); req = 8'h00;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a5_valid_%0d", i), {31'd0, valid}, 32'd1);
            chk($sformatf("a5_code_%0d", i), {29'd0, code}, {29'd0, exp_a5[i]});
            ack = 1'b1;
            tick(); ack = 1'b0;
            chk($sformatf("a5_gap_%0d", i), {31'd0, valid}, 32'd0);
            tick();
        end
        chk("a5_busy", {31'd0, busy}, 32'd0);

        // Code frozen while a higher-priority bit arrives
        req = 8'h10;
        tick(); req = 8'h00;
        tick();
        chk("frz_code0", {29'd0, code}, 32'd3);
        tick();
        req = 8'h80;
        tick(); req = 8'h00;
        tick();
        chk("frz_code1", {29'd0, code}, 32'd3);
        chk("frz_valid1", {31'd0, valid}, 32'd1);
        chk("frz_pending", {24'd0, pending}, 32'h90);
        ack = 1'b1;
        tick(); ack = 1'b0;
        chk("frz_pending_after", {24'd0, pending}, 32'h80);
        tick();
        chk("frz_next_code", {29'd0, code}, 32'd0);
        chk("frz_next_valid", {31'd0, valid}, 32'd1);
        drain("frz");

        // Ack and re-request of the same bit in one cycle
        req = 8'h10;
        tick(); req = 8'h00;
        tick();
        chk("same_code0", {29'd0, code}, 32'd3);
        ack = 1'b1; req = 8'h10;
        tick(); ack = 1'b0; req = 8'h00;
        chk("same_pending", {24'd0, pending}, 32'h10);
        chk("same_valid_gap", {31'd0, valid}, 32'd0);
        tick();
        chk("same_code1", {29'd0, code}, 32'd3);
        chk("same_valid1", {31'd0, valid}, 32'd1);
        drain("same");

        // Re-request of an already pending bit is absorbed
        req = 8'h04;
        tick(); req = 8'h00;
        tick(); req = 8'h04;
        tick(); req = 8'h00;
        chk("absorb_pending", {24'd0, pending}, 32'h04);
        ack = 1'b1;
        tick(); ack = 1'b0;
        tick();
        chk("absorb_done", {31'd0, busy}, 32'd0);

        // en=0 blocks capture
        en = 1'b0; req = 8'h10;
        tick(); req = 8'h00;
        tick(); tick();
        chk("en0_pending", {24'd0, pending}, 32'h0);
        chk("en0_valid", {31'd0, valid}, 32'd0);

        // en=0 still serves already pending bits
        en = 1'b1; req = 8'h20;
        tick(); req = 8'h00; en = 1'b0;
        tick();
        chk("en0_serve_code", {29'd0, code}, 32'd2);
        chk("en0_serve_valid", {31'd0, valid}, 32'd1);
        drain("en0_serve");
        en = 1'b1;

        // clr with a held line must not re-trigger
        req = 8'hFF;
        tick();
        tick();
        chk("clr_code", {29'd0, code}, 32'd0);
        clr = 1'b1;
        tick(); clr = 1'b0;
        chk("clr_pending", {24'd0, pending}, 32'h0);
        chk("clr_valid", {31'd0, valid}, 32'd0);
        tick(); tick();
        chk("clr_held_pending", {24'd0, pending}, 32'h0);
        chk("clr_held_busy", {31'd0, busy}, 32'd0);

        // All eight lines together: codes 0..7
        req = 8'h00;
        tick();
        req = 8'hFF;
        tick(); req = 8'h00;
        chk("all_pending", {24'd0, pending}, 32'hFF);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("all_code_%0d", k), {29'd0, code}, k);
            chk($sformatf("all_valid_%0d", k), {31'd0, valid}, 32'd1);
            ack = 1'b1;
            tick(); ack = 1'b0;
            tick();
        end
        chk("all_busy", {31'd0, busy}, 32'd0);

        // Level mode: held line is re-presented after every ack
        en2 = 1'b1; req2 = 8'h40;
        tick();
        chk("lvl_pending", {24'd0, pending2}, 32'h40);
        tick();
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("lvl_code_%0d", r), {29'd0, code2}, 32'd1);
            chk($sformatf("lvl_valid_%0d", r), {31'd0, valid2}, 32'd1);
            ack2 = 1'b1;
            tick(); ack2 = 1'b0;
            chk($sformatf("lvl_keep_%0d", r), {24'd0, pending2}, 32'h40);
            tick();
        end
        clr2 = 1'b1;
        tick(); clr2 = 1'b0; req2 = 8'h00;
        chk("lvl_clr_valid", {31'd0, valid2}, 32'd0);
        chk("lvl_clr_pending", {24'd0, pending2}, 32'h0);

        // Reset while presenting loses the code
        req = 8'h02;
        tick(); req = 8'h00;
        tick();
        chk("rstp_code", {29'd0, code}, 32'd6);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rstp_valid", {31'd0, valid}, 32'd0);
        chk("rstp_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rstp_stay", {31'd0, valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
